row_clear_engine: RTL and testbench

ROW_CLEAR_ENGINE -- requirements
Module: row_clear_engine

---
 rtl/row_clear_engine_pkg.sv | 36 +++
 rtl/row_clear_engine.sv | 125 ++++++++++++
 tb/tb_row_clear_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/row_clear_engine_pkg.sv
// Shared board geometry, score table and FSM encoding for the row-clear engine.
package row_clear_engine_pkg;

    localparam int ROWS      = 21;
    localparam int COLS      = 12;
    localparam int PLAY_ROWS = 20;
    localparam int BOARD_W   = ROWS * COLS;

    localparam logic [COLS-1:0] EMPTY_ROW = 12'h801;
    localparam logic [COLS-1:0] FLOOR_ROW = 12'hFFF;

    localparam logic [3:0] SCORE_TBL [5] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd8};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_e;

    function automatic logic [BOARD_W-1:0] empty_board();
        logic [BOARD_W-1:0] b;
        for (int r = 0; r < PLAY_ROWS; r++)
            b[r*COLS +: COLS] = EMPTY_ROW;
        b[PLAY_ROWS*COLS +: COLS] = FLOOR_ROW;
        return b;
    endfunction

    // Four or more lines all earn the top table entry.
    function automatic logic [3:0] score_inc(input logic [4:0] lines);
        if (lines >= 5'd4)
            return SCORE_TBL[4];
        return SCORE_TBL[lines[2:0]];
    endfunction

endpackage

// File: rtl/row_clear_engine.sv
// Scans the locked board bottom-up, removes full rows one at a time by shifting
// everything above down, then publishes the board, line count and running score.
module row_clear_engine
    import row_clear_engine_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [BOARD_W-1:0] Game_In,
    output logic [BOARD_W-1:0] Game_Out,
    output logic               Busy,
    output logic               Done,
    output logic [4:0]         Lines,
    output logic [15:0]        Score
);

    localparam logic [4:0] LAST_ROW = 5'(PLAY_ROWS - 1);

    function automatic logic row_full(input logic [COLS-1:0] row);
        return &row;
    endfunction

    state_e              state_q, state_d;
    logic [BOARD_W-1:0]  board_q, board_d;
    logic [BOARD_W-1:0]  out_q, out_d;
    logic [4:0]          idx_q, idx_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [4:0]          lines_q, lines_d;
    logic [15:0]         score_q, score_d;
    logic                done_q, done_d;

    logic [COLS-1:0]     cur_row;
    logic [BOARD_W-1:0]  shifted;
    logic [16:0]         score_sum;

    // Row under test and the board with rows 0..idx moved down by one.
    always_comb begin
        cur_row = '0;
        shifted = board_q;
        for (int r = 0; r < PLAY_ROWS; r++) begin
            if (idx_q == 5'(r))
                cur_row = board_q[r*COLS +: COLS];
        end
        for (int r = 1; r < PLAY_ROWS; r++) begin
            if (5'(r) <= idx_q)
                shifted[r*COLS +: COLS] = board_q[(r-1)*COLS +: COLS];
        end
        shifted[0 +: COLS] = EMPTY_ROW;
    end

    assign score_sum = {1'b0, score_q} + 17'(score_inc(cnt_q));

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        out_d   = out_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        score_d = score_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    board_d = Game_In;
                    cnt_d   = '0;
                    idx_d   = LAST_ROW;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (row_full(cur_row)) begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = SHIFT;
                end else if (idx_q == 5'd0) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q - 5'd1;
                end
            end
            // Index is kept so the row that just received new contents is re-tested.
            SHIFT: begin
                board_d = shifted;
                state_d = SCAN;
            end
            FINISH: begin
                out_d   = board_q;
                lines_d = cnt_q;
                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            board_q <= empty_board();
            out_q   <= empty_board();
            idx_q   <= LAST_ROW;
            cnt_q   <= '0;
            lines_q <= '0;
            score_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            score_q <= score_d;
            done_q  <= done_d;
        end
    end

    assign Game_Out = out_q;
    assign Busy     = (state_q != IDLE);
    assign Done     = done_q;
    assign Lines    = lines_q;
    assign Score    = score_q;

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed bench for row_clear_engine: a table of board passes with hand-derived
// results, then abort, ignored-Start and score-saturation sequences.
module tb_row_clear_engine;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           Start;
    logic [251:0]   Game_In;
    logic [251:0]   Game_Out;
    logic           Busy;
    logic           Done;
    logic [4:0]     Lines;
    logic [15:0]    Score;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    row_clear_engine dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Game_In  (Game_In),
        .Game_Out (Game_Out),
        .Busy     (Busy),
        .Done     (Done),
        .Lines    (Lines),
        .Score    (Score)
    );

    typedef struct {
        logic [251:0] board_in;
        logic [251:0] exp_out;
        int           exp_lat;
        logic [4:0]   exp_lines;
        logic [15:0]  exp_score;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [251:0] mt();
        logic [251:0] b;
        for (int r = 0; r < 20; r++) b[r*12 +: 12] = 12'h801;
        b[240 +: 12] = 12'hFFF;
        return b;
    endfunction

    function automatic logic [251:0] setrow(input logic [251:0] b, input int r, input logic [11:0] v);
        logic [251:0] o;
        o = b;
        o[r*12 +: 12] = v;
        return o;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns edges from the Start sample to Done (-1 on timeout).
    task automatic run_pass(input logic [251:0] b, output int lat, output logic busy0);
        Start   = 1'b1;
        Game_In = b;
        @(posedge Clk); #1;
        Start   = 1'b0;
        Game_In = '1;
        busy0   = Busy;
        lat     = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge Clk); #1;
            if (Done) begin
                lat = n;
                break;
            end
        end
    endtask

    int           lat;
    logic         busy0;
    int           dones;
    logic [251:0] b;

    initial begin
        Rst     = 1'b1;
        Start   = 1'b0;
        Game_In = mt();

        // V0: empty board
        vecs[0] = '{mt(), mt(), 21, 5'd0, 16'd0};
        // V1: row 19 full, row 18 partial drops into row 19
        b = setrow(setrow(mt(), 19, 12'hFFF), 18, 12'h803);
        vecs[1] = '{b, setrow(mt(), 19, 12'h803), 23, 5'd1, 16'd1};
        // V2: tetris on rows 16-19
        b = mt();
        for (int r = 16; r < 20; r++) b = setrow(b, r, 12'hFFF);
        vecs[2] = '{b, mt(), 29, 5'd4, 16'd9};
        // V3: rows 19 and 17 full around a partial row 18
        b = setrow(setrow(setrow(mt(), 19, 12'hFFF), 18, 12'hC01), 17, 12'hFFF);
        vecs[3] = '{b, setrow(mt(), 19, 12'hC01), 25, 5'd2, 16'd12};
        // V4: rows 19 and 10 full; partial row 5 falls two rows to row 7
        b = setrow(setrow(setrow(mt(), 19, 12'hFFF), 10, 12'hFFF), 5, 12'h8F1);
        vecs[4] = '{b, setrow(mt(), 7, 12'h8F1), 25, 5'd2, 16'd15};
        // V5: only the top row full
        vecs[5] = '{setrow(mt(), 0, 12'hFFF), mt(), 23, 5'd1, 16'd16};
        // V6: rows 0, 18, 19 full
        b = setrow(setrow(setrow(mt(), 19, 12'hFFF), 18, 12'hFFF), 0, 12'hFFF);
        vecs[6] = '{b, mt(), 27, 5'd3, 16'd21};

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy",  256'(Busy),     256'(0));
        chk("rst_done",  256'(Done),     256'(0));
        chk("rst_lines", 256'(Lines),    256'(0));
        chk("rst_score", 256'(Score),    256'(0));
        chk("rst_board", 256'(Game_Out), 256'(mt()));
        Rst = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_pass(vecs[i].board_in, lat, busy0);
            chk($sformatf("v%0d_latency", i), 256'(lat),      256'(vecs[i].exp_lat));
            chk($sformatf("v%0d_busy",    i), 256'(busy0),    256'(1));
            chk($sformatf("v%0d_lines",   i), 256'(Lines),    256'(vecs[i].exp_lines));
            chk($sformatf("v%0d_score",   i), 256'(Score),    256'(vecs[i].exp_score));
            chk($sformatf("v%0d_board",   i), 256'(Game_Out), 256'(vecs[i].exp_out));
            chk($sformatf("v%0d_busy_end", i), 256'(Busy),    256'(0));
            repeat (3) @(posedge Clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 256'(Done),  256'(0));
            chk($sformatf("v%0d_hold",    i), 256'(Game_Out), 256'(vecs[i].exp_out));
        end

        // Second Start at edge 5 of a pass must be ignored.
        Start   = 1'b1;
        Game_In = setrow(mt(), 19, 12'hFFF);
        @(posedge Clk); #1;
        Start   = 1'b0;
        dones   = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 5) begin
                Start   = 1'b1;
                Game_In = '1;
            end
            @(posedge Clk); #1;
            if (n == 5) Start = 1'b0;
            if (Done) dones++;
        end
        chk("ign_done_count", 256'(dones),    256'(1));
        chk("ign_lines",      256'(Lines),    256'(1));
        chk("ign_score",      256'(Score),    256'(22));
        chk("ign_board",      256'(Game_Out), 256'(mt()));

        // Reset at edge 10 of a pass aborts it.
        Start   = 1'b1;
        Game_In = setrow(mt(), 19, 12'hFFF);
        @(posedge Clk); #1;
        Start   = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        chk("abort_busy",  256'(Busy),     256'(0));
        chk("abort_done",  256'(Done),     256'(0));
        chk("abort_score", 256'(Score),    256'(0));
        chk("abort_board", 256'(Game_Out), 256'(mt()));
        @(posedge Clk); #1;
        Rst   = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge Clk); #1;
            if (Done) dones++;
        end
        chk("abort_no_done",    256'(dones), 256'(0));
        chk("abort_score_hold", 256'(Score), 256'(0));

        // Preload the score near the top, then check saturation.
        force dut.score_q = 16'hFFFE;
        @(posedge Clk); #1;
        release dut.score_q;
        @(posedge Clk); #1;
        chk("preload_score", 256'(Score), 256'(16'hFFFE));
        run_pass(setrow(mt(), 19, 12'hFFF), lat, busy0);
        chk("sat1_latency", 256'(lat),   256'(23));
        chk("sat1_score",   256'(Score), 256'(16'hFFFF));
        @(posedge Clk); #1;
        b = mt();
        for (int r = 16; r < 20; r++) b = setrow(b, r, 12'hFFF);
        run_pass(b, lat, busy0);
        chk("sat4_lines", 256'(Lines), 256'(4));
        chk("sat4_score", 256'(Score), 256'(16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
